// File: rtl/car_traffic_pkg.sv
// Shared constants and types for the car motion stage of the VGA renderer.
package car_traffic_pkg;

    localparam int unsigned GRID_HEIGHT = 32;
    localparam int unsigned CAR_WIDTH   = 64;
    localparam int unsigned CAR_HEIGHT  = 32;

    localparam int unsigned SCREEN_W   = 640;
    localparam int unsigned LANE_1_ROW = 4;
    localparam int unsigned LANE_2_ROW = 8;
    localparam int unsigned LANE_3_ROW = 11;
    localparam int unsigned CAR1_X0    = 0;
    localparam int unsigned CAR2_X0    = 320;
    localparam int unsigned CAR3_X0    = 480;
    localparam int unsigned SPEED_INIT = 2;
    localparam int unsigned SPEED_MAX  = 9;
    localparam int unsigned LEVEL_MAX  = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FROZEN
    } state_t;

    function automatic logic [9:0] speed_of(input logic [2:0] lvl);
        logic [9:0] raw;
        raw = 10'(SPEED_INIT) + {7'd0, lvl};
        return (raw > 10'(SPEED_MAX)) ? 10'(SPEED_MAX) : raw;
    endfunction

endpackage

// File: rtl/car_traffic_lane_mover.sv
// One car's X register: advances by s per enabled step and wraps at the screen edge.
module lane_mover
    import car_traffic_pkg::*;
#(
    parameter bit         DIR_RIGHT = 1'b1,
    parameter logic [9:0] X0        = '0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       en,
    input  logic [9:0] s,
    output logic [9:0] x
);

    logic [10:0] sum_r;
    logic [9:0]  nxt;

    always_comb begin
        sum_r = {1'b0, x} + {1'b0, s};
        if (DIR_RIGHT) begin
            nxt = (sum_r >= 11'(SCREEN_W)) ? 10'(sum_r - 11'(SCREEN_W)) : sum_r[9:0];
        end else begin
            nxt = (x < s) ? 10'({1'b0, x} + 11'(SCREEN_W) - {1'b0, s}) : x - s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x <= X0;
        end else if (load) begin
            x <= X0;
        end else if (en) begin
            x <= nxt;
        end
    end

endmodule

// File: rtl/car_traffic.sv
// Car motion stage: tick divider, run/freeze FSM, speed level and three lane movers.
module car_traffic
    import car_traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 416667,
    parameter int unsigned FREEZE_STEPS = 90
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       collide,
    input  logic       level_up,
    output logic [9:0] carX_1,
    output logic [9:0] carX_2,
    output logic [9:0] carX_3,
    output logic [9:0] carY_1,
    output logic [9:0] carY_2,
    output logic [9:0] carY_3,
    output logic       step,
    output logic [2:0] level,
    output logic       frozen
);

    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned FW = (FREEZE_STEPS > 0) ? $clog2(FREEZE_STEPS + 1) : 1;

    state_t        state;
    logic [TW-1:0] tick;
    logic          tick_wrap;
    logic [FW-1:0] freeze_cnt;
    logic          move_en;
    logic          respawn;
    logic [9:0]    speed;

    assign tick_wrap = (tick == TW'(TICK_DIV - 1));
    assign speed     = speed_of(level);
    assign move_en   = (state == ST_RUN) && !collide && tick_wrap;
    // Exit on the wrap that completes the last held step, reloading spawn X in the same edge.
    assign respawn   = (state == ST_FROZEN) && tick_wrap && (freeze_cnt <= FW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick <= '0;
        end else begin
            tick <= tick_wrap ? '0 : tick + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            step       <= 1'b0;
            frozen     <= 1'b0;
            level      <= '0;
            freeze_cnt <= '0;
            carY_1     <= 10'(LANE_1_ROW * GRID_HEIGHT);
            carY_2     <= 10'(LANE_2_ROW * GRID_HEIGHT);
            carY_3     <= 10'(LANE_3_ROW * GRID_HEIGHT);
        end else begin
            step <= 1'b0;
            if (level_up && (level != 3'(LEVEL_MAX))) begin
                level <= level + 3'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (collide) begin
                        state      <= ST_FROZEN;
                        frozen     <= 1'b1;
                        freeze_cnt <= FW'(FREEZE_STEPS);
                    end else if (tick_wrap) begin
                        step <= 1'b1;
                    end
                end
                ST_FROZEN: begin
                    if (tick_wrap) begin
                        if (freeze_cnt <= FW'(1)) begin
                            state      <= ST_IDLE;
                            frozen     <= 1'b0;
                            freeze_cnt <= '0;
                        end else begin
                            freeze_cnt <= freeze_cnt - FW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    lane_mover #(.DIR_RIGHT(1'b1), .X0(10'(CAR1_X0))) u_car1 (
        .clk(clk), .rst_n(rst_n), .load(respawn), .en(move_en), .s(speed), .x(carX_1)
    );

    lane_mover #(.DIR_RIGHT(1'b0), .X0(10'(CAR2_X0))) u_car2 (
        .clk(clk), .rst_n(rst_n), .load(respawn), .en(move_en), .s(speed), .x(carX_2)
    );

    lane_mover #(.DIR_RIGHT(1'b1), .X0(10'(CAR3_X0))) u_car3 (
        .clk(clk), .rst_n(rst_n), .load(respawn), .en(move_en), .s(speed), .x(carX_3)
    );

endmodule

// File: tb/tb_car_traffic.sv
// Bench for car_traffic: cycle-level reference model plus directed scenario checks.
module tb_car_traffic;

    localparam int unsigned TD = 4;
    localparam int unsigned FS = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       collide = 1'b0;
    logic       level_up = 1'b0;
    logic [9:0] carX_1, carX_2, carX_3, carY_1, carY_2, carY_3;
    logic       step;
    logic [2:0] level;
    logic       frozen;

    int checks = 0;
    int errors = 0;

    car_traffic #(.TICK_DIV(TD), .FREEZE_STEPS(FS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .collide(collide), .level_up(level_up),
        .carX_1(carX_1), .carX_2(carX_2), .carX_3(carX_3),
        .carY_1(carY_1), .carY_2(carY_2), .carY_3(carY_3),
        .step(step), .level(level), .frozen(frozen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase counted from reset, positions as plain modular arithmetic.
    bit m_valid = 0, m_run = 0, m_frz = 0, m_step = 0;
    int m_cyc = 0, m_lvl = 0, m_fwraps = 0;
    int m_x[3];

    always @(posedge clk) begin
        bit wrap;
        int s;
        if (!rst_n) begin
            m_valid = 1; m_run = 0; m_frz = 0; m_step = 0;
            m_cyc = 0; m_lvl = 0; m_fwraps = 0;
            m_x[0] = 0; m_x[1] = 320; m_x[2] = 480;
        end else begin
            wrap = ((m_cyc % TD) == TD - 1);
            m_cyc++;
            s = (2 + m_lvl > 9) ? 9 : 2 + m_lvl;
            m_step = 0;
            if (m_frz) begin
                if (wrap) begin
                    m_fwraps++;
                    if (m_fwraps >= FS) begin
                        m_frz = 0;
                        m_x[0] = 0; m_x[1] = 320; m_x[2] = 480;
                    end
                end
            end else if (m_run) begin
                if (collide) begin
                    m_run = 0; m_frz = 1; m_fwraps = 0;
                end else if (wrap) begin
                    m_x[0] = (m_x[0] + s) % 640;
                    m_x[1] = (m_x[1] - s + 640) % 640;
                    m_x[2] = (m_x[2] + s) % 640;
                    m_step = 1;
                end
            end else if (start) begin
                m_run = 1;
            end
            if (level_up && m_lvl < 7) m_lvl++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("carX_1", int'(carX_1), m_x[0]);
            chk("carX_2", int'(carX_2), m_x[1]);
            chk("carX_3", int'(carX_3), m_x[2]);
            chk("carY_1", int'(carY_1), 128);
            chk("carY_2", int'(carY_2), 256);
            chk("carY_3", int'(carY_3), 352);
            chk("step", int'(step), int'(m_step));
            chk("level", int'(level), m_lvl);
            chk("frozen", int'(frozen), int'(m_frz));
        end
    end

    task automatic wait_step();
        int i;
        for (i = 0; i < 20; i++) begin
            @(negedge clk);
            if (step) break;
        end
        if (i == 20) chk("step_timeout", 0, 1);
    endtask

    initial begin
        int x0, x1, x2;
        repeat (3) @(negedge clk);
        chk("rst_carX_1", int'(carX_1), 0);
        chk("rst_carX_2", int'(carX_2), 320);
        chk("rst_carX_3", int'(carX_3), 480);
        chk("rst_level", int'(level), 0);
        chk("rst_frozen", int'(frozen), 0);
        chk("rst_step", int'(step), 0);

        rst_n = 1'b1;
        start = 1'b1;
        repeat (4) @(negedge clk);
        chk("first_step", int'(step), 1);
        chk("first_carX_1", int'(carX_1), 2);
        chk("first_carX_2", int'(carX_2), 318);
        chk("first_carX_3", int'(carX_3), 482);
        chk("first_carY_1", int'(carY_1), 128);

        for (int i = 0; i < 400 && carX_2 != 10'd0; i++) wait_step();
        wait_step();
        chk("left_wrap_carX_2", int'(carX_2), 638);

        for (int i = 0; i < 400 && carX_1 != 10'd638; i++) wait_step();
        wait_step();
        chk("right_wrap_carX_1", int'(carX_1), 0);

        // level_up coincident with the wrap cycle: this move still uses s=2
        repeat (3) @(negedge clk);
        x0 = int'(carX_1);
        level_up = 1'b1;
        @(negedge clk);
        level_up = 1'b0;
        chk("lvlwrap_step", int'(step), 1);
        chk("lvlwrap_carX_1", int'(carX_1), (x0 + 2) % 640);
        chk("lvlwrap_level", int'(level), 1);
        x0 = int'(carX_1);
        wait_step();
        chk("s3_carX_1", int'(carX_1), (x0 + 3) % 640);

        for (int i = 0; i < 7; i++) begin
            level_up = 1'b1;
            @(negedge clk);
            level_up = 1'b0;
            @(negedge clk);
        end
        chk("level_sat", int'(level), 7);
        wait_step();
        x0 = int'(carX_1);
        wait_step();
        chk("s9_carX_1", int'(carX_1), (x0 + 9) % 640);

        start = 1'b0;
        repeat (3) @(negedge clk);
        x0 = int'(carX_1); x1 = int'(carX_2); x2 = int'(carX_3);
        collide = 1'b1;
        @(negedge clk);
        collide = 1'b0;
        chk("coll_step", int'(step), 0);
        chk("coll_frozen", int'(frozen), 1);
        chk("coll_carX_1", int'(carX_1), x0);
        chk("coll_carX_2", int'(carX_2), x1);
        chk("coll_carX_3", int'(carX_3), x2);
        for (int i = 0; i < 20 && frozen; i++) @(negedge clk);
        chk("unfreeze", int'(frozen), 0);
        chk("respawn_carX_1", int'(carX_1), 0);
        chk("respawn_carX_2", int'(carX_2), 320);
        chk("respawn_carX_3", int'(carX_3), 480);
        chk("respawn_level", int'(level), 7);

        start = 1'b1;
        collide = 1'b1;
        @(negedge clk);
        collide = 1'b0;
        chk("idle_start_collide_frozen", int'(frozen), 0);
        repeat (6) @(negedge clk);

        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            level_up = 1'b1;
            @(negedge clk);
            level_up = 1'b0;
        end
        repeat (2) @(negedge clk);
        collide = 1'b1;
        @(negedge clk);
        collide = 1'b0;
        chk("frz_l3_frozen", int'(frozen), 1);
        chk("frz_l3_level", int'(level), 3);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_level", int'(level), 0);
        chk("midrst_frozen", int'(frozen), 0);
        chk("midrst_step", int'(step), 0);
        chk("midrst_carX_1", int'(carX_1), 0);
        chk("midrst_carX_2", int'(carX_2), 320);
        chk("midrst_carX_3", int'(carX_3), 480);
        rst_n = 1'b1;
        start = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
